// File: rtl/riscv_pkg.sv
// Shared core types: FU completion record, ROB tag width and the common ROB age comparison.
package riscv_pkg;

    localparam int ReorderBufferTagWidth = 4;

    typedef struct packed {
        logic                             valid;
        logic [ReorderBufferTagWidth-1:0] tag;
        logic [31:0]                      value;
        logic                             exception;
        logic [4:0]                       exc_cause;
        logic [4:0]                       fp_flags;
    } fu_complete_t;

    // True when entry is strictly younger than flush, both measured as distance from the ROB head.
    function automatic logic is_rob_younger(
        input logic [ReorderBufferTagWidth-1:0] entry,
        input logic [ReorderBufferTagWidth-1:0] flush,
        input logic [ReorderBufferTagWidth-1:0] head
    );
        logic [ReorderBufferTagWidth:0] e_dist;
        logic [ReorderBufferTagWidth:0] f_dist;
        e_dist = ({1'b0, entry} - {1'b0, head}) & {1'b0, {ReorderBufferTagWidth{1'b1}}};
        f_dist = ({1'b0, flush} - {1'b0, head}) & {1'b0, {ReorderBufferTagWidth{1'b1}}};
        return e_dist > f_dist;
    endfunction

endpackage

// File: rtl/fu_cdb_adapter.sv
// Buffers completions from one FU (no back-pressure) and requests a CDB slot for the oldest one,
// applying full and partial ROB flushes to anything still waiting.
module fu_cdb_adapter
    import riscv_pkg::*;
#(
    parameter int Depth            = 2,
    parameter int AlmostFullThresh = Depth - 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  fu_complete_t                     i_fu_complete,
    output fu_complete_t                     o_cdb_req,
    input  logic                             i_cdb_grant,
    input  logic                             i_flush,
    input  logic                             i_flush_en,
    input  logic [ReorderBufferTagWidth-1:0] i_flush_tag,
    input  logic [ReorderBufferTagWidth-1:0] i_rob_head_tag,
    output logic [$clog2(Depth):0]           o_count,
    output logic                             o_almost_full,
    output logic                             o_overflow
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    fu_complete_t    mem_r [Depth];
    logic [PtrW-1:0] head_r;
    logic [PtrW-1:0] tail_r;
    logic [CntW-1:0] count_r;
    fu_complete_t    req_r;
    logic            almost_full_r;
    logic            overflow_r;

    fu_complete_t    mem_nxt_s [Depth];
    logic [PtrW-1:0] head_nxt_s;
    logic [PtrW-1:0] tail_nxt_s;
    logic [CntW-1:0] count_nxt_s;
    logic            overflow_nxt_s;
    fu_complete_t    req_nxt_s;
    logic [CntW-1:0] kept_s;
    logic [CntW-1:0] base_cnt_s;
    logic [PtrW-1:0] wr_idx_s;
    logic            pop_s;
    logic            push_s;
    logic            accept_s;

    // Next-state: survivors of a partial flush form a prefix, so only the kept count matters.
    always_comb begin
        mem_nxt_s      = mem_r;
        head_nxt_s     = head_r;
        tail_nxt_s     = tail_r;
        count_nxt_s    = count_r;
        overflow_nxt_s = overflow_r;
        kept_s         = {CntW{1'b0}};
        accept_s       = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if ((CntW'(i) < count_r) &&
                !is_rob_younger(mem_r[head_r + PtrW'(i)].tag, i_flush_tag, i_rob_head_tag)) begin
                kept_s = kept_s + CntW'(1);
            end else begin
                kept_s = kept_s;
            end
        end
        base_cnt_s = i_flush_en ? kept_s : count_r;
        pop_s      = i_cdb_grant && (count_r != {CntW{1'b0}}) && (base_cnt_s != {CntW{1'b0}});
        push_s     = i_fu_complete.valid &&
                     !(i_flush_en && is_rob_younger(i_fu_complete.tag, i_flush_tag, i_rob_head_tag));
        wr_idx_s   = head_r + base_cnt_s[PtrW-1:0];

        if (i_flush) begin
            head_nxt_s  = tail_r;
            count_nxt_s = {CntW{1'b0}};
        end else begin
            if (push_s && (base_cnt_s == CntW'(Depth)) && !pop_s) begin
                overflow_nxt_s = 1'b1;
            end else if (push_s) begin
                accept_s            = 1'b1;
                mem_nxt_s[wr_idx_s] = i_fu_complete;
            end else begin
                accept_s = 1'b0;
            end
            count_nxt_s = base_cnt_s + CntW'(accept_s) - CntW'(pop_s);
            head_nxt_s  = head_r + PtrW'(pop_s);
            tail_nxt_s  = wr_idx_s + PtrW'(accept_s);
        end

        req_nxt_s       = mem_nxt_s[head_nxt_s];
        req_nxt_s.valid = (count_nxt_s != {CntW{1'b0}});
    end

    // State and registered outputs; reset clears payloads so nothing stale is ever presented.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_r[i] <= '0;
            end
            head_r        <= {PtrW{1'b0}};
            tail_r        <= {PtrW{1'b0}};
            count_r       <= {CntW{1'b0}};
            req_r         <= '0;
            almost_full_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            mem_r         <= mem_nxt_s;
            head_r        <= head_nxt_s;
            tail_r        <= tail_nxt_s;
            count_r       <= count_nxt_s;
            req_r         <= req_nxt_s;
            almost_full_r <= (count_nxt_s >= CntW'(AlmostFullThresh));
            overflow_r    <= overflow_nxt_s;
        end
    end

    assign o_cdb_req     = req_r;
    assign o_count       = count_r;
    assign o_almost_full = almost_full_r;
    assign o_overflow    = overflow_r;

endmodule

// File: tb/tb_fu_cdb_adapter.sv
// Scoreboard bench for fu_cdb_adapter: expected completions are queued when driven and
// compared in order when granted off the CDB request.
module tb_fu_cdb_adapter;
    import riscv_pkg::*;

    localparam int DEPTH = 2;

    logic         i_clk = 1'b0;
    logic         i_rst;
    fu_complete_t i_fu_complete;
    fu_complete_t o_cdb_req;
    logic         i_cdb_grant;
    logic         i_flush;
    logic         i_flush_en;
    logic [3:0]   i_flush_tag;
    logic [3:0]   i_rob_head_tag;
    logic [1:0]   o_count;
    logic         o_almost_full;
    logic         o_overflow;

    fu_complete_t sb_q[$];
    logic         ovf_exp;
    int           checks   = 0;
    int           failures = 0;

    fu_cdb_adapter #(.Depth(DEPTH), .AlmostFullThresh(DEPTH - 1)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_fu_complete  (i_fu_complete),
        .o_cdb_req      (o_cdb_req),
        .i_cdb_grant    (i_cdb_grant),
        .i_flush        (i_flush),
        .i_flush_en     (i_flush_en),
        .i_flush_tag    (i_flush_tag),
        .i_rob_head_tag (i_rob_head_tag),
        .o_count        (o_count),
        .o_almost_full  (o_almost_full),
        .o_overflow     (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic bit tb_younger(input int e, input int f, input int h);
        return ((e - h) & 15) > ((f - h) & 15);
    endfunction

    task automatic check_outputs(input string ctx);
        check_val({ctx, "_count"}, 32'(o_count), 32'(sb_q.size()));
        check_val({ctx, "_afull"}, 32'(o_almost_full), 32'(sb_q.size() >= DEPTH - 1));
        check_val({ctx, "_ovf"}, 32'(o_overflow), 32'(ovf_exp));
        check_val({ctx, "_valid"}, 32'(o_cdb_req.valid), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            check_val({ctx, "_head_tag"}, 32'(o_cdb_req.tag), 32'(sb_q[0].tag));
            check_val({ctx, "_head_val"}, o_cdb_req.value, sb_q[0].value);
        end
    endtask

    // Update the model for the inputs currently driven, clock once, then compare.
    task automatic step(input string ctx);
        fu_complete_t exp_e;
        bit           pop;
        bit           accept;
        if (i_flush) begin
            sb_q.delete();
        end else begin
            if (i_flush_en) begin
                for (int i = sb_q.size() - 1; i >= 0; i--) begin
                    if (tb_younger(int'(sb_q[i].tag), int'(i_flush_tag), int'(i_rob_head_tag)))
                        sb_q.delete(i);
                end
            end
            pop    = i_cdb_grant && (sb_q.size() != 0);
            accept = i_fu_complete.valid &&
                     !(i_flush_en && tb_younger(int'(i_fu_complete.tag), int'(i_flush_tag),
                                                int'(i_rob_head_tag)));
            if (pop) begin
                exp_e = sb_q.pop_front();
                check_val({ctx, "_grant_tag"}, 32'(o_cdb_req.tag), 32'(exp_e.tag));
                check_val({ctx, "_grant_val"}, o_cdb_req.value, exp_e.value);
            end
            if (accept) begin
                if (sb_q.size() == DEPTH && !pop) ovf_exp = 1'b1;
                else sb_q.push_back(i_fu_complete);
            end
        end
        @(posedge i_clk);
        #1;
        i_fu_complete = '0;
        i_cdb_grant   = 1'b0;
        i_flush       = 1'b0;
        i_flush_en    = 1'b0;
        check_outputs(ctx);
    endtask

    task automatic drive_push(input logic [3:0] tag, input logic [31:0] value);
        i_fu_complete           = '0;
        i_fu_complete.valid     = 1'b1;
        i_fu_complete.tag       = tag;
        i_fu_complete.value     = value;
        i_fu_complete.exc_cause = tag[3:0] + 5'd1;
        i_fu_complete.fp_flags  = 5'h15;
    endtask

    initial begin
        i_rst          = 1'b1;
        i_fu_complete  = '0;
        i_cdb_grant    = 1'b0;
        i_flush        = 1'b0;
        i_flush_en     = 1'b0;
        i_flush_tag    = 4'd0;
        i_rob_head_tag = 4'd0;
        ovf_exp        = 1'b0;
        #23;
        check_outputs("reset");
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // 1: single push with grant held; request visible one cycle after the strobe.
        drive_push(4'd5, 32'h1234); i_cdb_grant = 1'b1; step("t1_push");
        i_cdb_grant = 1'b1; step("t1_grant");

        // 2: fill, overflow on third push, then drain in order.
        drive_push(4'd3, 32'h300); step("t2_push3");
        drive_push(4'd4, 32'h400); step("t2_push4");
        drive_push(4'd6, 32'h600); step("t2_push6_ovf");
        i_cdb_grant = 1'b1; step("t2_grant_a");
        i_cdb_grant = 1'b1; step("t2_grant_b");

        // 3: full buffer, simultaneous push and grant.
        drive_push(4'd3, 32'h301); step("t3_push3");
        drive_push(4'd4, 32'h401); step("t3_push4");
        drive_push(4'd7, 32'h701); i_cdb_grant = 1'b1; step("t3_push_pop");
        i_cdb_grant = 1'b1; step("t3_grant_a");
        i_cdb_grant = 1'b1; step("t3_grant_b");

        // 4: partial flushes, linear and wrap-around age.
        i_rob_head_tag = 4'd2;
        drive_push(4'd3, 32'h302); step("t4_push3");
        drive_push(4'd5, 32'h502); step("t4_push5");
        i_flush_en = 1'b1; i_flush_tag = 4'd3; step("t4_pflush");
        i_cdb_grant = 1'b1; step("t4_grant");
        i_rob_head_tag = 4'd14;
        drive_push(4'd15, 32'hF00); step("t4_push15");
        drive_push(4'd1, 32'h100); step("t4_push1");
        i_flush_en = 1'b1; i_flush_tag = 4'd15; step("t4_pflush_wrap");
        i_cdb_grant = 1'b1; step("t4_grant_wrap");

        // 5: full flush with simultaneous push and grant.
        drive_push(4'd8, 32'h800); step("t5_push8");
        drive_push(4'd9, 32'h900); i_cdb_grant = 1'b1; i_flush = 1'b1; step("t5_flush");
        step("t5_idle");

        // 6: asynchronous reset with two entries buffered.
        drive_push(4'd1, 32'h11); step("t6_push1");
        drive_push(4'd2, 32'h22); step("t6_push2");
        i_rst = 1'b1;
        #1;
        sb_q.delete();
        ovf_exp = 1'b0;
        check_outputs("t6_async_rst");
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        drive_push(4'd10, 32'hA0); step("t6_push_after");
        i_cdb_grant = 1'b1; step("t6_grant_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fu_cdb_adapter.md
Name: fu_cdb_adapter

Overview:
- Sits between one functional-unit completion port (for example, the MUL or DIV fu_complete_t output) and one CDB arbiter slot.
- FUs have no back-pressure, so every valid completion is captured into a small in-order buffer.
- The buffer head is presented to the arbiter as a request; an entry is held until the arbiter grants it.
- Applies full and partial flushes to buffered results and reports occupancy so the issue side can stall.

Parameters:
- Depth, 2, number of buffered completions (power of 2, ≥2).
- AlmostFullThresh, Depth-1, occupancy at or above which o_almost_full asserts.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_fu_complete  in  fu_complete_t  FU result; .valid is a single-cycle strobe, with no ready signal.
- o_cdb_req  out  fu_complete_t  buffer head; .valid means an arbitration request.
- i_cdb_grant  in  1  arbiter grant for this slot; only meaningful while o_cdb_req.valid.
- i_flush  in  1  full flush.
- i_flush_en  in  1  partial flush enable.
- i_flush_tag  in  ReorderBufferTagWidth  partial flush boundary; entries strictly younger are discarded.
- i_rob_head_tag  in  ReorderBufferTagWidth  ROB head, used for the age comparison.
- o_count  out  $clog2(Depth)+1  current occupancy.
- o_almost_full  out  1  o_count ≥ AlmostFullThresh; drives issue stall into the FU shim.
- o_overflow  out  1  sticky error: a push was attempted while full.

Behaviour:
- Reset (async, i_rst=1):
  - Head, tail and count go to 0.
  - o_cdb_req.valid=0, o_count=0, o_almost_full=0, o_overflow=0.
  - All entry payloads go to 0.
  - Reset mid-operation discards every entry immediately.
- Storage is a circular buffer of fu_complete_t with head/tail pointers and a count.
  - Pointers wrap modulo Depth.
  - Entries are in program order, because each FU has one in-flight operation.
- Push: when i_fu_complete.valid=1, the payload is written at the tail at the clock edge. It appears on o_cdb_req no earlier than the next cycle, so latency is 1 cycle from strobe to request when the buffer was empty. There is no combinational bypass.
- Request: o_cdb_req is driven from registers, equal to the head entry. .valid = (count≠0). Stable until granted or flushed.
- Pop: i_cdb_grant & o_cdb_req.valid advances head at the edge. A grant while .valid=0 is ignored.
- Simultaneous push and pop: count is unchanged. This is legal even when full: the pop frees the slot in the same edge, so no overflow.
- Full: a push while count==Depth with no same-cycle pop drops the payload and sets o_overflow (sticky until reset). Buffer contents are unchanged.
- Age compare: is_younger(e,f,h) = ((e−h) mod 2^W) > ((f−h) mod 2^W), computed with W+1-bit zero-extended subtraction.
- Full flush (i_flush=1): next count=0 and head=tail. The same-cycle push and the same-cycle grant are both discarded. Flush overrides everything except reset.
- Partial flush (i_flush_en=1, i_flush=0):
  - Every buffered entry with is_younger(tag, i_flush_tag, i_rob_head_tag) is discarded.
  - Because entries are ordered, the discarded entries form a suffix, so tail rolls back by the number of discarded entries.
  - A same-cycle push is accepted only if its tag is not younger.
  - A same-cycle grant of a surviving head still pops.
  - If the granted head itself is younger, the grant is discarded and no double decrement occurs.
  - The entry equal to i_flush_tag survives.
- o_count and o_almost_full are registered and reflect post-edge state.
- Exception, exc_cause and fp_flags pass through unmodified.

Decomposition:
- riscv_pkg: fu_complete_t (existing) and ReorderBufferTagWidth.
  - New shared function is_rob_younger(entry, flush, head), to replace per-module copies in the FU shims and reservation stations.
- No sub-module; a single flat module.

Test Plan:
1. Reset, then push tag=5 value=0x1234, grant held at 1 → o_cdb_req.valid=1 with tag=5 exactly one cycle after the strobe; valid=0 the following cycle; o_count 0→1→0.
2. Push tags 3 and 4 with grant held at 0 → count=2, o_almost_full=1. Third push tag=6 → dropped, o_overflow=1, head still tag 3. Two grants → 3 then 4 emitted in order.
3. Buffer full (tags 3, 4), grant plus push of tag 7 in the same cycle → count stays 2, no overflow, order 4, 7.
4. head_tag=2, buffer holds tags 3, 5, partial flush with flush_tag=3 → tag 5 removed, count=1, tag 3 still requested. Repeat with head_tag=14, W=4, tags 15, 1, flush_tag=15 → wrap-around case, tag 1 removed.
5. Full flush in the same cycle as a push of tag 9 and a grant of head tag 8 → count=0, o_cdb_req.valid=0 next cycle, tag 9 never appears.
6. Assert i_rst while count=2 → outputs zero asynchronously, before the next edge; after release, normal push works.
